// File: rtl/xc_malu_long_seq_if.sv
// xc_malu_long_seq_if: issue/writeback bundle for the self-sequenced MALU.
// The issue stage uses the master modport, the arithmetic unit the slave modport.
// With XC_MALU_LONG_SEQ_CARRY_CHAIN_EN defined the bundle also carries the chain request bit.
interface xc_malu_long_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic              valid;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   rs3;
    logic              uop_madd;
    logic              uop_msub;
    logic              uop_macc;
    logic              uop_mmul;
    logic              flush;
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
    logic              chain;
`endif
    logic              busy;
    logic              ready;
    logic [2*XLEN-1:0] result;

`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
    modport master (
        output valid, rs1, rs2, rs3, uop_madd, uop_msub, uop_macc, uop_mmul, flush, chain,
        input  busy, ready, result
    );
    modport slave (
        input  valid, rs1, rs2, rs3, uop_madd, uop_msub, uop_macc, uop_mmul, flush, chain,
        output busy, ready, result
    );
`else
    modport master (
        output valid, rs1, rs2, rs3, uop_madd, uop_msub, uop_macc, uop_mmul, flush,
        input  busy, ready, result
    );
    modport slave (
        input  valid, rs1, rs2, rs3, uop_madd, uop_msub, uop_macc, uop_mmul, flush,
        output busy, ready, result
    );
`endif
endinterface

// File: rtl/xc_malu_long_seq.sv
// xc_malu_long_seq: self-sequenced multi-precision add/sub/accumulate/multiply unit.
// One shared XLEN-bit adder serves ADD, ACC and HI; the multiplier retires MUL_BITS
// (1, 2 or 4, dividing XLEN) multiplier bits per cycle through its own partial-sum adder.
// Optional carry chaining between madd/msub limbs: XC_MALU_LONG_SEQ_CARRY_CHAIN_EN.
module xc_malu_long_seq #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input logic               g_clk,
    input logic               g_resetn,
    xc_malu_long_seq_if.slave bus
);
    localparam int unsigned     MulSteps = XLEN / MUL_BITS;
    localparam int unsigned     CntW     = $clog2(MulSteps) + 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(MulSteps - 1);

    typedef enum logic [2:0] {StIdle, StAdd, StHi, StMul, StAcc, StDone} state_e;
    typedef enum logic [2:0] {OpNone, OpMadd, OpMsub, OpMacc, OpMmul} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d, op_in;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic [2*XLEN-1:0] acc_q, acc_d, result_q, result_d;
    logic              carry_q, carry_d, cin_in;
    logic [CntW-1:0]   count_q, count_d;

    logic [XLEN-1:0]          add_a, add_b;
    logic                     add_cin, add_sub, add_cout_eff;
    logic [XLEN:0]            add_sum;
    logic [XLEN+MUL_BITS-1:0] mul_pp, mul_psum;

`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
    logic chain_carry_q;
`endif

    // Decode the uop (anything but exactly one bit is illegal) and pick the madd/msub carry-in.
    always_comb begin
        case ({bus.uop_mmul, bus.uop_macc, bus.uop_msub, bus.uop_madd})
            4'b0001: op_in = OpMadd;
            4'b0010: op_in = OpMsub;
            4'b0100: op_in = OpMacc;
            4'b1000: op_in = OpMmul;
            default: op_in = OpNone;
        endcase
        cin_in = bus.rs3[0];
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        if (bus.chain && (op_in == OpMadd || op_in == OpMsub)) cin_in = chain_carry_q;
`endif
    end

    // Shared adder operand select; subtraction is rs1 + ~rs2 + ~b0.
    always_comb begin
        add_a   = rs1_q;
        add_b   = rs2_q;
        add_cin = 1'b0;
        add_sub = 1'b0;
        case (state_q)
            StAdd: begin
                if (op_q == OpMacc) begin
                    add_a = rs2_q;
                    add_b = rs3_q;
                end else begin
                    add_sub = (op_q == OpMsub);
                    add_cin = (op_q == OpMsub) ? ~rs3_q[0] : rs3_q[0];
                end
            end
            StAcc: begin
                add_a = acc_q[XLEN-1:0];
                add_b = rs3_q;
            end
            StHi: begin
                add_a   = (op_q == OpMacc) ? rs1_q : acc_q[2*XLEN-1:XLEN];
                add_b   = '0;
                add_cin = carry_q;
            end
            default: ;
        endcase
    end

    assign add_sum      = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)}
                        + {{XLEN{1'b0}}, add_cin};
    // For msub the stored flag is the borrow, i.e. the inverted carry-out.
    assign add_cout_eff = (op_q == OpMsub) ? ~add_sum[XLEN] : add_sum[XLEN];

    // Multiplier partial sum: acc_hi + rs1 * (low MUL_BITS of acc), acc low half holds rs2.
    always_comb begin
        mul_pp = '0;
        for (int i = 0; i < int'(MUL_BITS); i++) begin
            if (acc_q[i]) mul_pp = mul_pp + ({{MUL_BITS{1'b0}}, rs1_q} << i);
        end
        mul_psum = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
    end

    // Next-state and datapath updates; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rs3_d    = rs3_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (bus.valid && !bus.flush) begin
                    op_d    = op_in;
                    rs1_d   = bus.rs1;
                    rs2_d   = bus.rs2;
                    rs3_d   = (op_in == OpMadd || op_in == OpMsub) ?
                              {bus.rs3[XLEN-1:1], cin_in} : bus.rs3;
                    count_d = '0;
                    carry_d = 1'b0;
                    acc_d   = (op_in == OpMmul) ? {{XLEN{1'b0}}, bus.rs2} : '0;
                    case (op_in)
                        OpNone: begin
                            state_d  = StDone;
                            result_d = '0;
                        end
                        OpMmul:  state_d = StMul;
                        default: state_d = StAdd;
                    endcase
                end
            end
            StAdd: begin
                acc_d   = {{XLEN{1'b0}}, add_sum[XLEN-1:0]};
                carry_d = add_cout_eff;
                if (op_q == OpMacc) begin
                    state_d = StHi;
                end else begin
                    result_d = {{(XLEN-1){1'b0}}, add_cout_eff, add_sum[XLEN-1:0]};
                    state_d  = StDone;
                end
            end
            StMul: begin
                acc_d   = {mul_psum, acc_q[XLEN-1:MUL_BITS]};
                count_d = count_q + CntW'(1);
                if (count_q == CntLast) state_d = StAcc;
            end
            StAcc: begin
                acc_d[XLEN-1:0] = add_sum[XLEN-1:0];
                carry_d         = add_sum[XLEN];
                state_d         = StHi;
            end
            StHi: begin
                acc_d[2*XLEN-1:XLEN] = add_sum[XLEN-1:0];
                result_d             = {add_sum[XLEN-1:0], acc_q[XLEN-1:0]};
                state_d              = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d  = StIdle;
            acc_d    = '0;
            carry_d  = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q  <= StIdle;
            op_q     <= OpNone;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rs3_q    <= rs3_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
    // Remember the madd carry / msub borrow of the last completed limb.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            chain_carry_q <= 1'b0;
        end else if (bus.flush) begin
            chain_carry_q <= 1'b0;
        end else if (state_q == StDone && (op_q == OpMadd || op_q == OpMsub)) begin
            chain_carry_q <= carry_q;
        end
    end
`endif

    assign bus.busy   = (state_q != StIdle);
    assign bus.ready  = (state_q == StDone);
    assign bus.result = result_q;
endmodule

// File: tb/tb_xc_malu_long_seq.sv
// tb_xc_malu_long_seq: randomized and directed bench for xc_malu_long_seq.
// Two DUTs (MUL_BITS=1 and MUL_BITS=4) see identical stimulus; a plain-arithmetic
// model provides the expected result and latency for each.
`timescale 1ns/1ps
module tb_xc_malu_long_seq;
    localparam int unsigned XLEN = 32;

    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    xc_malu_long_seq_if #(.XLEN(XLEN)) bus ();
    xc_malu_long_seq_if #(.XLEN(XLEN)) bus4 ();

    assign bus4.valid    = bus.valid;
    assign bus4.rs1      = bus.rs1;
    assign bus4.rs2      = bus.rs2;
    assign bus4.rs3      = bus.rs3;
    assign bus4.uop_madd = bus.uop_madd;
    assign bus4.uop_msub = bus.uop_msub;
    assign bus4.uop_macc = bus.uop_macc;
    assign bus4.uop_mmul = bus.uop_mmul;
    assign bus4.flush    = bus.flush;
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
    assign bus4.chain    = bus.chain;
    logic drive_chain = 1'b0;
    logic chain_model = 1'b0;
`endif

    xc_malu_long_seq #(.XLEN(XLEN), .MUL_BITS(1)) dut1 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );
    xc_malu_long_seq #(.XLEN(XLEN), .MUL_BITS(4)) dut4 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus4)
    );

    int checks = 0;
    int errors = 0;

    int          obs_lat[2];
    int          obs_rdy[2];
    int          obs_busy[2];
    logic [63:0] obs_res[2];
    logic        rdy_now[2];
    logic        busy_now[2];
    logic [63:0] res_now[2];

    typedef struct {
        logic [3:0]  u;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [63:0] exp;
    } vec_t;

    // Reference: exact arithmetic straight from the operation definitions.
    function automatic logic [63:0] model_res(input logic [3:0] u, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c,
                                              input logic cin);
        logic [63:0] wa, wb, wc, wi, low;
        logic        brw;
        wa = {32'b0, a};
        wb = {32'b0, b};
        wc = {32'b0, c};
        wi = {63'b0, cin};
        case (u)
            4'b0001: return wa + wb + wi;
            4'b0010: begin
                low = (wa - wb - wi) & 64'h0000_0000_FFFF_FFFF;
                brw = (wa < wb + wi);
                return low | {31'b0, brw, 32'b0};
            end
            4'b0100: return (wa << 32) + wb + wc;
            4'b1000: return wa * wb + wc;
            default: return 64'b0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] u, input int mb);
        case (u)
            4'b0001, 4'b0010: return 2;
            4'b0100:          return 3;
            4'b1000:          return 32 / mb + 3;
            default:          return 1;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic sample_outputs();
        rdy_now[0]  = bus.ready;
        rdy_now[1]  = bus4.ready;
        busy_now[0] = bus.busy;
        busy_now[1] = bus4.busy;
        res_now[0]  = bus.result;
        res_now[1]  = bus4.result;
    endtask

    task automatic drive_req(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
        bus.valid = 1'b1;
        {bus.uop_mmul, bus.uop_macc, bus.uop_msub, bus.uop_madd} = u;
        bus.rs1 = a;
        bus.rs2 = b;
        bus.rs3 = c;
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        bus.chain = drive_chain;
`endif
    endtask

    // Operands need not be held after acceptance, so trash them.
    task automatic scramble();
        bus.valid = 1'b0;
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
        bus.rs3   = $urandom;
        {bus.uop_mmul, bus.uop_macc, bus.uop_msub, bus.uop_madd} = 4'($urandom_range(0, 15));
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        bus.chain = 1'($urandom_range(0, 1));
`endif
    endtask

    // Issue one request and observe both DUTs for a fixed 40-cycle window.
    task automatic issue(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        @(negedge g_clk);
        drive_req(u, a, b, c);
        @(negedge g_clk);
        scramble();
        for (int d = 0; d < 2; d++) begin
            obs_lat[d]  = -1;
            obs_rdy[d]  = 0;
            obs_busy[d] = 0;
            obs_res[d]  = '0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            sample_outputs();
            for (int d = 0; d < 2; d++) begin
                if (busy_now[d]) obs_busy[d]++;
                if (rdy_now[d]) begin
                    obs_rdy[d]++;
                    if (obs_lat[d] < 0) begin
                        obs_lat[d] = cyc;
                        obs_res[d] = res_now[d];
                    end
                end
            end
            @(negedge g_clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge g_clk);
        sample_outputs();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_now[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset busy dut%0d: got %b want 0", d, busy_now[d]);
            end
            checks++;
            if (rdy_now[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset ready dut%0d: got %b want 0", d, rdy_now[d]);
            end
            checks++;
            if (res_now[d] !== 64'h0) begin
                errors++;
                $display("FAIL reset result dut%0d: got %h want 0", d, res_now[d]);
            end
        end
        g_resetn = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vecs[8];
        vecs[0] = '{4'b0001, 32'hFFFF_FFFF, 32'h1, 32'h1, 64'h0000_0001_0000_0001};
        vecs[1] = '{4'b0010, 32'h0, 32'h1, 32'h0, 64'h0000_0001_FFFF_FFFF};
        vecs[2] = '{4'b0010, 32'd5, 32'd3, 32'd1, 64'h0000_0000_0000_0001};
        vecs[3] = '{4'b0100, 32'h1, 32'hFFFF_FFFF, 32'h1, 64'h0000_0002_0000_0000};
        vecs[4] = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000};
        vecs[5] = '{4'b0001, 32'd2, 32'd3, 32'd0, 64'h5};
        vecs[6] = '{4'b0010, 32'd10, 32'd3, 32'hFFFF_FFFE, 64'h7};
        vecs[7] = '{4'b0001, 32'd1, 32'd1, 32'hFFFF_FFFE, 64'h2};
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        drive_chain = 1'b0;
`endif
        for (int v = 0; v < 8; v++) begin
            issue(vecs[v].u, vecs[v].a, vecs[v].b, vecs[v].c);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_lat[d] !== model_lat(vecs[v].u, (d == 0) ? 1 : 4)) begin
                    errors++;
                    $display("FAIL directed%0d latency dut%0d: got %0d want %0d", v, d,
                             obs_lat[d], model_lat(vecs[v].u, (d == 0) ? 1 : 4));
                end
                checks++;
                if (obs_res[d] !== vecs[v].exp) begin
                    errors++;
                    $display("FAIL directed%0d result dut%0d: got %h want %h", v, d,
                             obs_res[d], vecs[v].exp);
                end
                checks++;
                if (obs_busy[d] !== obs_lat[d] || obs_rdy[d] !== 1) begin
                    errors++;
                    $display("FAIL directed%0d busy/ready dut%0d: got busy %0d ready %0d want %0d/1",
                             v, d, obs_busy[d], obs_rdy[d], obs_lat[d]);
                end
            end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
            if (vecs[v].u == 4'b0001 || vecs[v].u == 4'b0010) chain_model = vecs[v].exp[32];
`endif
        end
    endtask

    task automatic test_random();
        logic [3:0]  u;
        logic [31:0] a, b, c;
        logic        cin;
        logic [63:0] exp;
        for (int n = 0; n < 40; n++) begin
            u = 4'b0001 << $urandom_range(0, 3);
            a = pick();
            b = pick();
            c = pick();
            cin = c[0];
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
            drive_chain = 1'($urandom_range(0, 1));
            if (drive_chain && (u == 4'b0001 || u == 4'b0010)) cin = chain_model;
`endif
            exp = model_res(u, a, b, c, cin);
            issue(u, a, b, c);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_lat[d] !== model_lat(u, (d == 0) ? 1 : 4)) begin
                    errors++;
                    $display("FAIL random%0d latency dut%0d: got %0d want %0d", n, d,
                             obs_lat[d], model_lat(u, (d == 0) ? 1 : 4));
                end
                checks++;
                if (obs_res[d] !== exp) begin
                    errors++;
                    $display("FAIL random%0d result dut%0d op %b: got %h want %h", n, d, u,
                             obs_res[d], exp);
                end
                checks++;
                if (obs_busy[d] !== obs_lat[d] || obs_rdy[d] !== 1) begin
                    errors++;
                    $display("FAIL random%0d busy/ready dut%0d: got busy %0d ready %0d", n, d,
                             obs_busy[d], obs_rdy[d]);
                end
            end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
            if (u == 4'b0001 || u == 4'b0010) chain_model = exp[32];
            drive_chain = 1'b0;
`endif
        end
    endtask

    task automatic test_illegal();
        logic [3:0] us[4];
        us[0] = 4'b1001;
        us[1] = 4'b0000;
        us[2] = 4'b0110;
        us[3] = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            issue(4'b0001, 32'h1234, 32'h1, 32'h0);  // leave a non-zero result behind
            issue(us[k], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_lat[d] !== 1) begin
                    errors++;
                    $display("FAIL illegal %b latency dut%0d: got %0d want 1", us[k], d,
                             obs_lat[d]);
                end
                checks++;
                if (obs_res[d] !== 64'h0) begin
                    errors++;
                    $display("FAIL illegal %b result dut%0d: got %h want 0", us[k], d,
                             obs_res[d]);
                end
            end
        end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        chain_model = 1'b0;
`endif
    endtask

    task automatic test_flush();
        int rdy_seen[2];
        // Flush ten cycles into a multiply.
        @(negedge g_clk);
        drive_req(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h9);
        @(negedge g_clk);
        scramble();
        repeat (9) @(negedge g_clk);
        bus.flush = 1'b1;
        @(negedge g_clk);
        bus.flush = 1'b0;
        sample_outputs();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_now[d] !== 1'b0) begin
                errors++;
                $display("FAIL flush busy dut%0d: got %b want 0", d, busy_now[d]);
            end
            rdy_seen[d] = 0;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            sample_outputs();
            for (int d = 0; d < 2; d++) if (rdy_now[d]) rdy_seen[d]++;
            @(negedge g_clk);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy_seen[d] !== 0) begin
                errors++;
                $display("FAIL flush no-ready dut%0d: got %0d pulses want 0", d, rdy_seen[d]);
            end
        end
        // valid in the same cycle as flush is ignored.
        drive_req(4'b0001, 32'd1, 32'd1, 32'd0);
        bus.flush = 1'b1;
        @(negedge g_clk);
        scramble();
        bus.flush = 1'b0;
        sample_outputs();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_now[d] !== 1'b0) begin
                errors++;
                $display("FAIL flush+valid busy dut%0d: got %b want 0", d, busy_now[d]);
            end
        end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        chain_model = 1'b0;
`endif
        // Normal operation afterwards.
        issue(4'b0001, 32'd2, 32'd3, 32'd0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_res[d] !== 64'h5 || obs_lat[d] !== 2) begin
                errors++;
                $display("FAIL post-flush madd dut%0d: got %h lat %0d want 5 lat 2", d,
                         obs_res[d], obs_lat[d]);
            end
        end
        // Flush in the DONE cycle still lets ready pulse.
        @(negedge g_clk);
        drive_req(4'b0001, 32'd3, 32'd4, 32'd0);
        @(negedge g_clk);
        scramble();
        @(negedge g_clk);
        bus.flush = 1'b1;
        sample_outputs();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy_now[d] !== 1'b1 || res_now[d] !== 64'h7) begin
                errors++;
                $display("FAIL flush-in-done dut%0d: got ready %b result %h want 1/7", d,
                         rdy_now[d], res_now[d]);
            end
        end
        @(negedge g_clk);
        bus.flush = 1'b0;
        sample_outputs();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy_now[d] !== 1'b0 || busy_now[d] !== 1'b0) begin
                errors++;
                $display("FAIL after flush-in-done dut%0d: got ready %b busy %b want 0/0", d,
                         rdy_now[d], busy_now[d]);
            end
        end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        chain_model = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        int          first_cyc[2];
        int          second_cyc[2];
        int          pulses[2];
        logic [63:0] first_res[2];
        logic [63:0] second_res[2];
        logic [63:0] exp_a, exp_b;
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        drive_chain = 1'b0;
`endif
        exp_a = model_res(4'b0001, 32'h8000_0000, 32'h8000_0001, 32'h0, 1'b0);
        exp_b = model_res(4'b0010, 32'h10, 32'h20, 32'h1, 1'b1);
        @(negedge g_clk);
        drive_req(4'b0001, 32'h8000_0000, 32'h8000_0001, 32'h0);
        @(negedge g_clk);
        drive_req(4'b0010, 32'h10, 32'h20, 32'h1);  // held from ADD through the next IDLE
        for (int d = 0; d < 2; d++) begin
            first_cyc[d]  = -1;
            second_cyc[d] = -1;
            pulses[d]     = 0;
            first_res[d]  = '0;
            second_res[d] = '0;
        end
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 4) scramble();
            sample_outputs();
            for (int d = 0; d < 2; d++) begin
                if (rdy_now[d]) begin
                    pulses[d]++;
                    if (first_cyc[d] < 0) begin
                        first_cyc[d] = cyc;
                        first_res[d] = res_now[d];
                    end else if (second_cyc[d] < 0) begin
                        second_cyc[d] = cyc;
                        second_res[d] = res_now[d];
                    end
                end
            end
            @(negedge g_clk);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (first_cyc[d] !== 2 || first_res[d] !== exp_a) begin
                errors++;
                $display("FAIL b2b first dut%0d: got cyc %0d res %h want 2 %h", d,
                         first_cyc[d], first_res[d], exp_a);
            end
            checks++;
            if (second_cyc[d] !== 5 || second_res[d] !== exp_b || pulses[d] !== 2) begin
                errors++;
                $display("FAIL b2b second dut%0d: got cyc %0d res %h pulses %0d want 5 %h 2",
                         d, second_cyc[d], second_res[d], pulses[d], exp_b);
            end
        end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        chain_model = exp_b[32];
`endif
    endtask

    task automatic test_reset_mid();
        int rdy_seen[2];
        @(negedge g_clk);
        drive_req(4'b0100, 32'h1, 32'hFFFF_FFFF, 32'h1);
        @(negedge g_clk);
        scramble();
        #2 g_resetn = 1'b0;
        #1 sample_outputs();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_now[d] !== 1'b0 || rdy_now[d] !== 1'b0 || res_now[d] !== 64'h0) begin
                errors++;
                $display("FAIL mid reset dut%0d: got busy %b ready %b result %h want 0/0/0", d,
                         busy_now[d], rdy_now[d], res_now[d]);
            end
            rdy_seen[d] = 0;
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            sample_outputs();
            for (int d = 0; d < 2; d++) if (rdy_now[d]) rdy_seen[d]++;
            @(negedge g_clk);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy_seen[d] !== 0) begin
                errors++;
                $display("FAIL post-reset ready dut%0d: got %0d pulses want 0", d, rdy_seen[d]);
            end
        end
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        chain_model = 1'b0;
`endif
    endtask

`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
    task automatic test_chain();
        logic [3:0]  us[5];
        logic [31:0] as[5], bs[5], cs[5];
        logic        chs[5];
        logic [63:0] exps[5];
        us[0] = 4'b0001; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h1; cs[0] = 32'h0; chs[0] = 1'b0;
        exps[0] = 64'h0000_0001_0000_0000;
        us[1] = 4'b0001; as[1] = 32'h0; bs[1] = 32'h0; cs[1] = 32'h0; chs[1] = 1'b1;
        exps[1] = 64'h1;
        us[2] = 4'b0010; as[2] = 32'h0; bs[2] = 32'h1; cs[2] = 32'h0; chs[2] = 1'b0;
        exps[2] = 64'h0000_0001_FFFF_FFFF;
        us[3] = 4'b0010; as[3] = 32'd5; bs[3] = 32'd3; cs[3] = 32'h0; chs[3] = 1'b1;
        exps[3] = 64'h1;
        us[4] = 4'b0001; as[4] = 32'h0; bs[4] = 32'h0; cs[4] = 32'h1; chs[4] = 1'b1;
        exps[4] = 64'h0;
        for (int k = 0; k < 5; k++) begin
            drive_chain = chs[k];
            issue(us[k], as[k], bs[k], cs[k]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_res[d] !== exps[k]) begin
                    errors++;
                    $display("FAIL chain%0d result dut%0d: got %h want %h", k, d, obs_res[d],
                             exps[k]);
                end
            end
        end
        drive_chain = 1'b0;
        chain_model = 1'b0;
    endtask
`endif

    initial begin
        g_resetn     = 1'b1;
        bus.valid    = 1'b0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.rs3      = '0;
        bus.uop_madd = 1'b0;
        bus.uop_msub = 1'b0;
        bus.uop_macc = 1'b0;
        bus.uop_mmul = 1'b0;
        bus.flush    = 1'b0;
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        bus.chain    = 1'b0;
`endif
        #1 g_resetn = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_reset_mid();
`ifdef XC_MALU_LONG_SEQ_CARRY_CHAIN_EN
        test_chain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
